// File: rtl/sipo_parity_rx_if.sv
// Bus bundle for the serial parity receiver: strobed serial input on one side,
// valid/ready parallel word with status flags on the other.
interface sipo_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              sin;
  logic              sin_valid;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  // Environment side: feeds the serial line and consumes words
  modport master (
    output sin, sin_valid, dout_ready,
    input  dout, dout_valid, parity_err, frame_err, overrun
  );

  // Receiver side
  modport slave (
    input  sin, sin_valid, dout_ready,
    output dout, dout_valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/sipo_parity_rx.sv
// Serial-to-parallel framed receiver with XOR parity check.
// Frame: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// The receive FSM never stalls; a completed frame that finds the output
// register full is dropped and reported through a one-cycle overrun pulse.
module sipo_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  sipo_parity_rx_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              perr_hold_q, perr_hold_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              frame_done;

  // Next-state logic: frame FSM plus the output register and status pulses
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    perr_hold_d  = perr_hold_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    frame_done   = 1'b0;

    if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.sin_valid && !bus.sin) begin
          state_d = DATA;
          cnt_d   = '0;
          par_d   = PARITY_ODD;
        end
      end
      DATA: begin
        if (bus.sin_valid) begin
          shift_d[cnt_q] = bus.sin;
          par_d          = par_q ^ bus.sin;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bus.sin_valid) begin
          perr_hold_d = par_q ^ bus.sin;
          state_d     = STOP;
        end
      end
      STOP: begin
        if (bus.sin_valid) begin
          state_d = IDLE;
          if (bus.sin) begin
            frame_done = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_done) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = shift_q;
        parity_err_d = perr_hold_q;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      perr_hold_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      perr_hold_q  <= perr_hold_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_parity_rx.sv
// Bench for sipo_parity_rx: an even-parity and an odd-parity instance receive
// the same serial stream; a frame-level model (queue of strobed bits) predicts
// every output on every cycle.
module tb_sipo_parity_rx;

  localparam int DW = 8;

  logic clk;
  logic rst;

  sipo_parity_rx_if #(.DATA_W(DW)) bus_e ();
  sipo_parity_rx_if #(.DATA_W(DW)) bus_o ();

  sipo_parity_rx #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut_even (
    .clk (clk),
    .rst (rst),
    .bus (bus_e.slave)
  );

  sipo_parity_rx #(.DATA_W(DW), .PARITY_ODD(1'b1)) dut_odd (
    .clk (clk),
    .rst (rst),
    .bus (bus_o.slave)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared   = 0;
  int mismatched = 0;

  // Model state
  bit            bits[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic          exp_pe_even;
  logic          exp_pe_odd;
  logic          exp_ferr;
  logic          exp_ovr;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("even_dout",       32'(bus_e.dout),       32'(exp_dout));
    checkVal("even_dout_valid", 32'(bus_e.dout_valid), 32'(exp_valid));
    checkVal("even_parity_err", 32'(bus_e.parity_err), 32'(exp_pe_even));
    checkVal("even_frame_err",  32'(bus_e.frame_err),  32'(exp_ferr));
    checkVal("even_overrun",    32'(bus_e.overrun),    32'(exp_ovr));
    checkVal("odd_dout",        32'(bus_o.dout),       32'(exp_dout));
    checkVal("odd_dout_valid",  32'(bus_o.dout_valid), 32'(exp_valid));
    checkVal("odd_parity_err",  32'(bus_o.parity_err), 32'(exp_pe_odd));
    checkVal("odd_frame_err",   32'(bus_o.frame_err),  32'(exp_ferr));
    checkVal("odd_overrun",     32'(bus_o.overrun),    32'(exp_ovr));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare
  task automatic applyStimulus(input logic b, input logic v, input logic r);
    logic [DW-1:0] n_dout;
    logic [DW-1:0] data;
    logic          n_valid, n_pe_e, n_pe_o, n_ferr, n_ovr, pbit, stopb;
    bus_e.sin = b; bus_e.sin_valid = v; bus_e.dout_ready = r;
    bus_o.sin = b; bus_o.sin_valid = v; bus_o.dout_ready = r;
    n_dout  = exp_dout;
    n_valid = exp_valid;
    n_pe_e  = exp_pe_even;
    n_pe_o  = exp_pe_odd;
    n_ferr  = 1'b0;
    n_ovr   = 1'b0;
    data    = '0;
    if (exp_valid && r) n_valid = 1'b0;
    if (v && !(bits.size() == 0 && b)) begin
      bits.push_back(b);
      if (bits.size() == DW + 3) begin
        for (int i = 0; i < DW; i++) data[i] = bits[i+1];
        pbit  = bits[DW+1];
        stopb = bits[DW+2];
        bits.delete();
        if (stopb) begin
          if (!exp_valid || r) begin
            n_dout  = data;
            n_pe_e  = (^data) ^ pbit;
            n_pe_o  = ~((^data) ^ pbit);
            n_valid = 1'b1;
          end else begin
            n_ovr = 1'b1;
          end
        end else begin
          n_ferr = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    exp_dout    = n_dout;
    exp_valid   = n_valid;
    exp_pe_even = n_pe_e;
    exp_pe_odd  = n_pe_o;
    exp_ferr    = n_ferr;
    exp_ovr     = n_ovr;
    checkOutput();
  endtask

  function automatic logic pickRdy(input int m);
    if (m == 2) return logic'($urandom_range(0, 1));
    return (m != 0);
  endfunction

  task automatic idleCycles(input int n, input int rdy);
    for (int i = 0; i < n; i++) applyStimulus(logic'($urandom_range(0, 1)), 1'b0, pickRdy(rdy));
  endtask

  // Send one frame with random non-strobed gaps; rdyStop applies to the stop strobe only
  task automatic sendFrame(input logic [DW-1:0] data, input logic pbit, input logic stopb,
                           input int rdyBody, input int rdyStop, input int gapMax);
    logic fr [DW+3];
    fr[0] = 1'b0;
    for (int i = 0; i < DW; i++) fr[i+1] = data[i];
    fr[DW+1] = pbit;
    fr[DW+2] = stopb;
    for (int k = 0; k < DW + 3; k++) begin
      idleCycles(int'($urandom_range(0, gapMax)), rdyBody);
      applyStimulus(fr[k], 1'b1, pickRdy((k == DW + 2) ? rdyStop : rdyBody));
    end
  endtask

  // Asynchronous reset pulse away from the clock edge
  task automatic doReset();
    bus_e.sin_valid = 1'b0; bus_o.sin_valid = 1'b0;
    rst = 1'b1;
    #2;
    bits.delete();
    exp_dout = '0; exp_valid = 1'b0; exp_pe_even = 1'b0; exp_pe_odd = 1'b0;
    exp_ferr = 1'b0; exp_ovr = 1'b0;
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput();
  endtask

  // Directed steps followed by randomized frames
  initial begin
    logic [DW-1:0] rd;
    rst = 1'b1;
    bus_e.sin = 1'b1; bus_e.sin_valid = 1'b0; bus_e.dout_ready = 1'b0;
    bus_o.sin = 1'b1; bus_o.sin_valid = 1'b0; bus_o.dout_ready = 1'b0;
    exp_dout = '0; exp_valid = 1'b0; exp_pe_even = 1'b0; exp_pe_odd = 1'b0;
    exp_ferr = 1'b0; exp_ovr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    idleCycles(2, 1);

    $display("[TB] basic 0xA5 frame");
    sendFrame(8'hA5, 1'b0, 1'b1, 1, 1, 0);
    checkVal("a5_dout", 32'(bus_e.dout), 32'h0A5);
    checkVal("a5_valid", 32'(bus_e.dout_valid), 32'd1);
    checkVal("a5_perr_even", 32'(bus_e.parity_err), 32'd0);
    checkVal("a5_perr_odd", 32'(bus_o.parity_err), 32'd1);
    idleCycles(1, 1);
    checkVal("a5_valid_one_cycle", 32'(bus_e.dout_valid), 32'd0);

    $display("[TB] 0xA5 with parity bit 1");
    sendFrame(8'hA5, 1'b1, 1'b1, 1, 1, 1);
    checkVal("a5p1_dout", 32'(bus_e.dout), 32'h0A5);
    checkVal("a5p1_perr_even", 32'(bus_e.parity_err), 32'd1);
    checkVal("a5p1_perr_odd", 32'(bus_o.parity_err), 32'd0);
    idleCycles(2, 1);

    $display("[TB] stop bit 0 then 0x81");
    sendFrame(8'h3C, 1'b0, 1'b0, 1, 1, 1);
    checkVal("3c_frame_err", 32'(bus_e.frame_err), 32'd1);
    checkVal("3c_valid", 32'(bus_e.dout_valid), 32'd0);
    idleCycles(1, 1);
    checkVal("3c_frame_err_pulse", 32'(bus_e.frame_err), 32'd0);
    sendFrame(8'h81, 1'b0, 1'b1, 1, 1, 1);
    checkVal("81_dout", 32'(bus_e.dout), 32'h081);
    checkVal("81_perr", 32'(bus_e.parity_err), 32'd0);
    idleCycles(2, 1);

    $display("[TB] overrun with consumer stalled");
    sendFrame(8'h11, 1'b0, 1'b1, 0, 0, 1);
    sendFrame(8'h22, 1'b0, 1'b1, 0, 0, 1);
    checkVal("ovr_pulse", 32'(bus_e.overrun), 32'd1);
    checkVal("ovr_dout_kept", 32'(bus_e.dout), 32'h011);
    idleCycles(1, 0);
    checkVal("ovr_pulse_once", 32'(bus_e.overrun), 32'd0);
    checkVal("ovr_still_valid", 32'(bus_e.dout_valid), 32'd1);
    idleCycles(1, 1);
    checkVal("ready_drops_valid", 32'(bus_e.dout_valid), 32'd0);

    $display("[TB] ready in completion cycle");
    sendFrame(8'h11, 1'b0, 1'b1, 0, 0, 0);
    sendFrame(8'h55, 1'b0, 1'b1, 0, 1, 1);
    checkVal("55_dout", 32'(bus_e.dout), 32'h055);
    checkVal("55_valid", 32'(bus_e.dout_valid), 32'd1);
    checkVal("55_no_overrun", 32'(bus_e.overrun), 32'd0);
    idleCycles(2, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idleCycles(int'($urandom_range(1, 3)), 1);
      applyStimulus(logic'(i[0]), 1'b1, 1'b1);
    end
    idleCycles(1, 1);
    doReset();
    checkVal("rst_dout", 32'(bus_e.dout), 32'd0);
    sendFrame(8'hF0, 1'b0, 1'b1, 1, 1, 2);
    checkVal("f0_dout", 32'(bus_e.dout), 32'h0F0);
    checkVal("f0_perr", 32'(bus_e.parity_err), 32'd0);
    idleCycles(2, 1);

    $display("[TB] randomized frames");
    for (int n = 0; n < 40; n++) begin
      rd = DW'($urandom);
      sendFrame(rd, (^rd) ^ ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 2, 2, 2);
      idleCycles(int'($urandom_range(0, 3)), 2);
    end
    idleCycles(3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
